// File: rtl/fir_decim_mc.sv
// Multi-channel decimating FIR: time-interleaved channels share one MAC that runs
// once per channel every DECIMATION input frames, then dequantises toward zero.
module fir_decim_mc #(
  parameter int NUM_TAPS     = 32,
  parameter int NUM_CHANNELS = 2,
  parameter int DECIMATION   = 8,
  parameter int DATA_W       = 32,
  parameter int QUANT_BITS   = 10,
  parameter logic [0:NUM_TAPS-1][DATA_W-1:0] COEFFS = {
    32'hfffffffd, 32'hfffffffa, 32'hfffffff4, 32'hffffffed,
    32'hffffffe5, 32'hffffffdf, 32'hffffffe2, 32'hfffffff3,
    32'h00000015, 32'h0000004e, 32'h0000009b, 32'h000000f9,
    32'h0000015d, 32'h000001be, 32'h0000020e, 32'h00000243,
    32'h00000243, 32'h0000020e, 32'h000001be, 32'h0000015d,
    32'h000000f9, 32'h0000009b, 32'h0000004e, 32'h00000015,
    32'hfffffff3, 32'hffffffe2, 32'hffffffdf, 32'hffffffe5,
    32'hffffffed, 32'hfffffff4, 32'hfffffffa, 32'hfffffffd
  }
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_empty,
  output logic              in_rd_en,
  input  logic [DATA_W-1:0] in_dout,
  input  logic              out_full,
  output logic              out_wr_en,
  output logic [DATA_W-1:0] out_din
);

  localparam int MW    = 2 * DATA_W;
  localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int PH_W  = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
  localparam int TAP_W = $clog2(NUM_TAPS);

  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CHANNELS - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(DECIMATION - 1);
  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(NUM_TAPS - 1);
  localparam logic signed [MW-1:0] BIAS = (MW'(1) << QUANT_BITS) - MW'(1);

  typedef enum logic [1:0] {
    S_READ,
    S_MAC,
    S_DQ,
    S_WRITE
  } state_t;

  state_t state_q, state_d;

  logic [CH_W-1:0]        ch_q;
  logic [PH_W-1:0]        ph_q;
  logic [TAP_W-1:0]       k_q;
  logic signed [MW-1:0]   acc_q;
  logic [DATA_W-1:0]      x_q [NUM_CHANNELS][NUM_TAPS];

  logic                   phase_last;
  logic                   ch_last;
  logic                   tap_last;
  logic                   advance;
  logic signed [DATA_W-1:0] x_sel;
  logic signed [DATA_W-1:0] c_sel;
  logic signed [MW-1:0]   prod;
  logic signed [MW-1:0]   acc_biased;
  logic signed [MW-1:0]   quot;

  always_comb begin
    phase_last = (ph_q == PH_LAST);
    ch_last    = (ch_q == CH_LAST);
    tap_last   = (k_q == TAP_LAST);
  end

  // Next-state and handshake strobes; in_rd_en depends only on state and in_empty.
  always_comb begin
    state_d   = state_q;
    in_rd_en  = 1'b0;
    out_wr_en = 1'b0;
    case (state_q)
      S_READ: begin
        if (!in_empty) begin
          in_rd_en = 1'b1;
          if (phase_last) state_d = S_MAC;
        end
      end
      S_MAC: begin
        if (tap_last) state_d = S_DQ;
      end
      S_DQ: begin
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (!out_full) begin
          out_wr_en = 1'b1;
          state_d   = S_READ;
        end
      end
      default: state_d = S_READ;
    endcase
  end

  // ch/ph stay frozen on the triggering read so the MAC sees the latched channel;
  // they move on only once that channel's result has been written.
  always_comb begin
    advance = (in_rd_en && !phase_last) || out_wr_en;
  end

  always_comb begin
    x_sel      = $signed(x_q[ch_q][k_q]);
    c_sel      = $signed(COEFFS[k_q]);
    prod       = MW'(x_sel) * MW'(c_sel);
    acc_biased = acc_q + (acc_q[MW-1] ? BIAS : '0);
    quot       = acc_biased >>> QUANT_BITS;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_READ;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ch_q    <= '0;
      ph_q    <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      out_din <= '0;
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        for (int unsigned t = 0; t < NUM_TAPS; t++) begin
          x_q[CH_W'(c)][TAP_W'(t)] <= '0;
        end
      end
    end else begin
      if (in_rd_en) begin
        x_q[ch_q][0] <= in_dout;
        for (int unsigned t = 1; t < NUM_TAPS; t++) begin
          x_q[ch_q][TAP_W'(t)] <= x_q[ch_q][TAP_W'(t - 1)];
        end
        if (phase_last) begin
          acc_q <= '0;
          k_q   <= '0;
        end
      end

      if (state_q == S_MAC) begin
        acc_q <= acc_q + prod;
        k_q   <= tap_last ? '0 : k_q + TAP_W'(1);
      end

      if (state_q == S_DQ) begin
        out_din <= quot[DATA_W-1:0];
      end

      if (advance) begin
        if (ch_last) begin
          ch_q <= '0;
          ph_q <= phase_last ? '0 : ph_q + PH_W'(1);
        end else begin
          ch_q <= ch_q + CH_W'(1);
        end
      end
    end
  end

endmodule
